// File: rtl/axil_demux_pkg.sv
// Shared types and constants for the AXI4-Lite address demultiplexer.
// Holds the write/read FSM state enums, the AXI response codes and a helper
// that sizes the slave-index field so it is never zero bits wide.
package axil_demux_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FWD,
        W_RESP,
        W_ERR
    } write_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_RESP,
        R_ERR
    } read_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A single slave still needs a one-bit index so every select compare stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bundle used on both sides of the demultiplexer.
// Ports: none; the master modport drives the request channels and the
// response readies, the slave modport drives the opposite directions.
interface axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_demux_decode.sv
// Combinational address decoder: maps a full AXI address onto one of
// SLAVE_NUM equally sized windows starting at BASE_ADDR.
// Ports: addr (in)  - full transaction address
//        hit  (out) - address falls inside one of the slave windows
//        idx  (out) - window index, meaningful only when hit is set
module axil_demux_decode
    import axil_demux_pkg::*;
#(
    parameter int                  SLAVE_NUM = 3,
    parameter int                  ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'h4000_0000,
    parameter int                  SPAN_LOG2 = 12
) (
    input  logic [ADDR_W-1:0]                   addr,
    output logic                                hit,
    output logic [idx_width(SLAVE_NUM)-1:0]     idx
);
    localparam int IDX_W = idx_width(SLAVE_NUM);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx_full;

    // Below-base addresses wrap to a huge offset, so the explicit >= test is
    // what rejects them; the full-width index compare rejects above-range ones.
    assign off      = addr - BASE_ADDR;
    assign idx_full = off >> SPAN_LOG2;
    assign hit      = (addr >= BASE_ADDR) && (idx_full < ADDR_W'(SLAVE_NUM));
    assign idx      = idx_full[IDX_W-1:0];

endmodule

// File: rtl/axil_addr_demux.sv
// 1-to-N AXI4-Lite address demultiplexer. One CPU/bridge master on s_axil is
// routed to SLAVE_NUM slave windows on m_axil; unmapped addresses get a local
// DECERR. Write and read paths are independent, one outstanding each.
// Ports: clk_i   - system clock
//        arstn_i - asynchronous active-low reset
//        s_axil  - upstream master connection
//        m_axil  - downstream slaves, index i serves window i
module axil_addr_demux
    import axil_demux_pkg::*;
#(
    parameter int                           SLAVE_NUM       = 3,
    parameter int                           AXIL_ADDR_WIDTH = 32,
    parameter int                           AXIL_DATA_WIDTH = 32,
    parameter logic [AXIL_ADDR_WIDTH-1:0]   BASE_ADDR       = 32'h4000_0000,
    parameter int                           SPAN_LOG2       = 12
) (
    input  logic  clk_i,
    input  logic  arstn_i,
    axil_if.slave  s_axil,
    axil_if.master m_axil [SLAVE_NUM]
);
    localparam int IDX_W  = idx_width(SLAVE_NUM);
    localparam int STRB_W = AXIL_DATA_WIDTH / 8;

    logic                        w_hit, r_hit;
    logic [IDX_W-1:0]            w_idx, r_idx;

    write_state_t                w_state, w_state_nxt;
    read_state_t                 r_state, r_state_nxt;

    logic [AXIL_ADDR_WIDTH-1:0]  aw_addr_q, ar_addr_q;
    logic [AXIL_DATA_WIDTH-1:0]  w_data_q;
    logic [STRB_W-1:0]           w_strb_q;
    logic [2:0]                  aw_prot_q, ar_prot_q;
    logic [IDX_W-1:0]            w_sel_q, r_sel_q;
    logic                        aw_valid_q, w_valid_q, ar_valid_q;

    logic                        aw_accept, ar_accept;
    logic                        s_bvalid, s_rvalid, m_bready, m_rready;
    logic [1:0]                  s_bresp, s_rresp;
    logic [AXIL_DATA_WIDTH-1:0]  s_rdata;

    logic [SLAVE_NUM-1:0]        awready_vec, wready_vec, bvalid_vec;
    logic [SLAVE_NUM-1:0]        arready_vec, rvalid_vec;
    logic [1:0]                  bresp_arr [SLAVE_NUM];
    logic [1:0]                  rresp_arr [SLAVE_NUM];
    logic [AXIL_DATA_WIDTH-1:0]  rdata_arr [SLAVE_NUM];

    logic                        sel_awready, sel_wready, sel_bvalid;
    logic                        sel_arready, sel_rvalid;
    logic [1:0]                  sel_bresp, sel_rresp;
    logic [AXIL_DATA_WIDTH-1:0]  sel_rdata;

    axil_demux_decode #(
        .SLAVE_NUM (SLAVE_NUM),
        .ADDR_W    (AXIL_ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .SPAN_LOG2 (SPAN_LOG2)
    ) u_w_decode (
        .addr (s_axil.awaddr),
        .hit  (w_hit),
        .idx  (w_idx)
    );

    axil_demux_decode #(
        .SLAVE_NUM (SLAVE_NUM),
        .ADDR_W    (AXIL_ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .SPAN_LOG2 (SPAN_LOG2)
    ) u_r_decode (
        .addr (s_axil.araddr),
        .hit  (r_hit),
        .idx  (r_idx)
    );

    // Fan the latched request out to every slave; only the selected one ever
    // sees a valid or ready, the address/data buses are simply broadcast.
    for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_slave
        localparam logic [IDX_W-1:0] IDX = IDX_W'(i);

        assign m_axil[i].awaddr  = aw_addr_q;
        assign m_axil[i].awprot  = aw_prot_q;
        assign m_axil[i].awvalid = aw_valid_q && (w_sel_q == IDX);
        assign m_axil[i].wdata   = w_data_q;
        assign m_axil[i].wstrb   = w_strb_q;
        assign m_axil[i].wvalid  = w_valid_q && (w_sel_q == IDX);
        assign m_axil[i].bready  = m_bready && (w_sel_q == IDX);
        assign m_axil[i].araddr  = ar_addr_q;
        assign m_axil[i].arprot  = ar_prot_q;
        assign m_axil[i].arvalid = ar_valid_q && (r_sel_q == IDX);
        assign m_axil[i].rready  = m_rready && (r_sel_q == IDX);

        assign awready_vec[i] = m_axil[i].awready;
        assign wready_vec[i]  = m_axil[i].wready;
        assign bvalid_vec[i]  = m_axil[i].bvalid;
        assign bresp_arr[i]   = m_axil[i].bresp;
        assign arready_vec[i] = m_axil[i].arready;
        assign rvalid_vec[i]  = m_axil[i].rvalid;
        assign rresp_arr[i]   = m_axil[i].rresp;
        assign rdata_arr[i]   = m_axil[i].rdata;
    end

    // Pick out the selected slave's handshake and response signals. A loop
    // compare is used instead of direct indexing so an index past SLAVE_NUM
    // (non-power-of-two counts) reads as zero rather than out of range.
    always_comb begin
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        sel_bvalid  = 1'b0;
        sel_bresp   = RESP_OKAY;
        sel_arready = 1'b0;
        sel_rvalid  = 1'b0;
        sel_rresp   = RESP_OKAY;
        sel_rdata   = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (w_sel_q == IDX_W'(i)) begin
                sel_awready = awready_vec[i];
                sel_wready  = wready_vec[i];
                sel_bvalid  = bvalid_vec[i];
                sel_bresp   = bresp_arr[i];
            end
            if (r_sel_q == IDX_W'(i)) begin
                sel_arready = arready_vec[i];
                sel_rvalid  = rvalid_vec[i];
                sel_rresp   = rresp_arr[i];
                sel_rdata   = rdata_arr[i];
            end
        end
    end

    // Write FSM next-state and outputs. AW and W are only ever accepted
    // together so the latched request is always complete.
    always_comb begin
        w_state_nxt = w_state;
        aw_accept   = 1'b0;
        s_bvalid    = 1'b0;
        s_bresp     = RESP_OKAY;
        m_bready    = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_accept = s_axil.awvalid && s_axil.wvalid;
                if (aw_accept) begin
                    w_state_nxt = w_hit ? W_FWD : W_ERR;
                end
            end
            W_FWD: begin
                if ((!aw_valid_q || sel_awready) && (!w_valid_q || sel_wready)) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                s_bvalid = sel_bvalid;
                s_bresp  = sel_bresp;
                m_bready = s_axil.bready;
                if (sel_bvalid && s_axil.bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_ERR: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_DECERR;
                if (s_axil.bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM next-state and outputs; a decode miss answers with zero data.
    always_comb begin
        r_state_nxt = r_state;
        ar_accept   = 1'b0;
        s_rvalid    = 1'b0;
        s_rresp     = RESP_OKAY;
        s_rdata     = '0;
        m_rready    = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_accept = s_axil.arvalid;
                if (ar_accept) begin
                    r_state_nxt = r_hit ? R_FWD : R_ERR;
                end
            end
            R_FWD: begin
                if (!ar_valid_q || sel_arready) begin
                    r_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                s_rvalid = sel_rvalid;
                s_rresp  = sel_rresp;
                s_rdata  = sel_rdata;
                m_rready = s_axil.rready;
                if (sel_rvalid && s_axil.rready) begin
                    r_state_nxt = R_IDLE;
                end
            end
            R_ERR: begin
                s_rvalid = 1'b1;
                s_rresp  = RESP_DECERR;
                if (s_axil.rready) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign s_axil.awready = aw_accept;
    assign s_axil.wready  = aw_accept;
    assign s_axil.bvalid  = s_bvalid;
    assign s_axil.bresp   = s_bresp;
    assign s_axil.arready = ar_accept;
    assign s_axil.rvalid  = s_rvalid;
    assign s_axil.rresp   = s_rresp;
    assign s_axil.rdata   = s_rdata;

    // State registers for both paths.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    // Request latches and registered downstream valids. A miss latches the
    // request but never raises a valid, so no slave sees the transaction.
    // Each valid drops on its own handshake so AW and W may complete apart.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            aw_addr_q  <= '0;
            aw_prot_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            w_sel_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_addr_q  <= '0;
            ar_prot_q  <= '0;
            r_sel_q    <= '0;
            ar_valid_q <= 1'b0;
        end else begin
            if (aw_accept) begin
                aw_addr_q  <= s_axil.awaddr;
                aw_prot_q  <= s_axil.awprot;
                w_data_q   <= s_axil.wdata;
                w_strb_q   <= s_axil.wstrb;
                w_sel_q    <= w_idx;
                aw_valid_q <= w_hit;
                w_valid_q  <= w_hit;
            end else begin
                if (aw_valid_q && sel_awready) aw_valid_q <= 1'b0;
                if (w_valid_q && sel_wready)   w_valid_q  <= 1'b0;
            end
            if (ar_accept) begin
                ar_addr_q  <= s_axil.araddr;
                ar_prot_q  <= s_axil.arprot;
                r_sel_q    <= r_idx;
                ar_valid_q <= r_hit;
            end else if (ar_valid_q && sel_arready) begin
                ar_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_addr_demux.sv
// Self-checking bench for axil_addr_demux with three responder slaves whose
// ready delays and read data are set per step from the stimulus block.
module tb_axil_addr_demux;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic arstn;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t wr_q[$];
    exp_t rd_q[$];

    logic [3:0]  aw_delay  [3];
    logic [3:0]  w_delay   [3];
    logic [3:0]  ar_delay  [3];
    logic [31:0] rdata_val [3];

    axil_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
    axil_if #(.ADDR_W(32), .DATA_W(32)) m_if [3] ();

    axil_addr_demux #(.SLAVE_NUM(3)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .s_axil  (s_if),
        .m_axil  (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder slaves: ready rises after a programmable number of valid
    // cycles, a write response follows once both AW and W have been taken,
    // and a read response follows the AR handshake. Handshake payloads and
    // valid-cycle counts are recorded for the stimulus block to inspect.
    for (genvar g = 0; g < 3; g++) begin : gen_slv
        logic [3:0]  aw_wait, w_wait, ar_wait;
        logic        got_aw, got_w, bvalid_r, rvalid_r;
        logic [31:0] rdata_r, cap_awaddr, cap_wdata, cap_araddr;
        logic [3:0]  cap_wstrb;
        logic        aw_hs, w_hs, ar_hs;
        int          aw_cnt = 0;
        int          w_cnt  = 0;
        int          ar_cnt = 0;

        assign m_if[g].awready = m_if[g].awvalid && (aw_wait >= aw_delay[g]);
        assign m_if[g].wready  = m_if[g].wvalid  && (w_wait  >= w_delay[g]);
        assign m_if[g].arready = m_if[g].arvalid && (ar_wait >= ar_delay[g]);
        assign m_if[g].bvalid  = bvalid_r;
        assign m_if[g].bresp   = 2'b00;
        assign m_if[g].rvalid  = rvalid_r;
        assign m_if[g].rdata   = rdata_r;
        assign m_if[g].rresp   = 2'b00;
        assign aw_hs = m_if[g].awvalid && m_if[g].awready;
        assign w_hs  = m_if[g].wvalid  && m_if[g].wready;
        assign ar_hs = m_if[g].arvalid && m_if[g].arready;

        always @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                aw_wait  <= '0;
                w_wait   <= '0;
                ar_wait  <= '0;
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
                bvalid_r <= 1'b0;
                rvalid_r <= 1'b0;
                rdata_r  <= '0;
            end else begin
                if (m_if[g].awvalid) aw_cnt <= aw_cnt + 1;
                if (m_if[g].wvalid)  w_cnt  <= w_cnt + 1;
                if (m_if[g].arvalid) ar_cnt <= ar_cnt + 1;
                if (aw_hs) begin
                    aw_wait    <= '0;
                    cap_awaddr <= m_if[g].awaddr;
                end else if (m_if[g].awvalid) begin
                    aw_wait <= aw_wait + 4'd1;
                end
                if (w_hs) begin
                    w_wait    <= '0;
                    cap_wdata <= m_if[g].wdata;
                    cap_wstrb <= m_if[g].wstrb;
                end else if (m_if[g].wvalid) begin
                    w_wait <= w_wait + 4'd1;
                end
                if (bvalid_r) begin
                    if (m_if[g].bready) bvalid_r <= 1'b0;
                end else if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                    bvalid_r <= 1'b1;
                    got_aw   <= 1'b0;
                    got_w    <= 1'b0;
                end else begin
                    got_aw <= got_aw || aw_hs;
                    got_w  <= got_w || w_hs;
                end
                if (ar_hs) begin
                    ar_wait    <= '0;
                    cap_araddr <= m_if[g].araddr;
                    rvalid_r   <= 1'b1;
                    rdata_r    <= rdata_val[g];
                end else begin
                    if (m_if[g].arvalid) ar_wait <= ar_wait + 4'd1;
                    if (rvalid_r && m_if[g].rready) rvalid_r <= 1'b0;
                end
            end
        end
    end

    // Total valid cycles ever seen by one slave, used to prove it stayed idle.
    function automatic int valid_total(input int k);
        case (k)
            0:       return gen_slv[0].aw_cnt + gen_slv[0].w_cnt + gen_slv[0].ar_cnt;
            1:       return gen_slv[1].aw_cnt + gen_slv[1].w_cnt + gen_slv[1].ar_cnt;
            default: return gen_slv[2].aw_cnt + gen_slv[2].w_cnt + gen_slv[2].ar_cnt;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a write (AW+W together) and/or a read at a negedge, confirm the
    // same-cycle accept, then drop the valids one cycle later (cycle N+1).
    task automatic applyStimulus(input string tag,
                                 input bit do_wr, input logic [31:0] waddr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input bit do_rd, input logic [31:0] raddr);
        if (do_wr) begin
            s_if.awaddr  = waddr;
            s_if.wdata   = wdata;
            s_if.wstrb   = wstrb;
            s_if.awvalid = 1'b1;
            s_if.wvalid  = 1'b1;
        end
        if (do_rd) begin
            s_if.araddr  = raddr;
            s_if.arvalid = 1'b1;
        end
        #1;
        if (do_wr) begin
            checkOutput({tag, "_awready"}, s_if.awready, 1'b1);
            checkOutput({tag, "_wready"},  s_if.wready,  1'b1);
        end
        if (do_rd) checkOutput({tag, "_arready"}, s_if.arready, 1'b1);
        @(negedge clk);
        s_if.awvalid = 1'b0;
        s_if.wvalid  = 1'b0;
        s_if.arvalid = 1'b0;
    endtask

    // Wait (bounded) for bvalid, then pop the scoreboard and compare bresp.
    task automatic waitB(input string tag, output int lat);
        exp_t e;
        bit   found = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_if.bvalid === 1'b1) begin
                found = 1'b1;
                break;
            end
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, "_bvalid_seen"}, found, 1'b1);
        checkOutput({tag, "_b_expected"}, (wr_q.size() > 0), 1'b1);
        if (found && wr_q.size() > 0) begin
            e = wr_q.pop_front();
            checkOutput({tag, "_bresp"}, s_if.bresp, e.resp);
        end
    endtask

    task automatic waitR(input string tag, output int lat);
        exp_t e;
        bit   found = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_if.rvalid === 1'b1) begin
                found = 1'b1;
                break;
            end
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, "_rvalid_seen"}, found, 1'b1);
        checkOutput({tag, "_r_expected"}, (rd_q.size() > 0), 1'b1);
        if (found && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            checkOutput({tag, "_rresp"}, s_if.rresp, e.resp);
            checkOutput({tag, "_rdata"}, s_if.rdata, e.data);
        end
    endtask

    initial begin
        int lat;
        int base1, base2, base_all, aw0, w0, ar1;

        for (int i = 0; i < 3; i++) begin
            aw_delay[i]  = 4'd0;
            w_delay[i]   = 4'd0;
            ar_delay[i]  = 4'd0;
            rdata_val[i] = 32'h0;
        end
        arstn        = 1'b0;
        s_if.awaddr  = '0;
        s_if.awprot  = '0;
        s_if.awvalid = 1'b0;
        s_if.wdata   = '0;
        s_if.wstrb   = '0;
        s_if.wvalid  = 1'b0;
        s_if.bready  = 1'b1;
        s_if.araddr  = '0;
        s_if.arprot  = '0;
        s_if.arvalid = 1'b0;
        s_if.rready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_bvalid",    s_if.bvalid,     1'b0);
        checkOutput("rst_rvalid",    s_if.rvalid,     1'b0);
        checkOutput("rst_m0_awvalid", m_if[0].awvalid, 1'b0);
        checkOutput("rst_m0_arvalid", m_if[0].arvalid, 1'b0);
        checkOutput("rst_m0_awaddr",  m_if[0].awaddr,  32'h0);
        arstn = 1'b1;
        @(negedge clk);

        // Write 0xA5 to slave 0
        base1 = valid_total(1);
        base2 = valid_total(2);
        wr_q.push_back('{resp: 2'b00, data: 32'h0});
        applyStimulus("wr0", 1'b1, 32'h4000_0004, 32'h0000_00A5, 4'hF, 1'b0, 32'h0);
        checkOutput("wr0_m0_awvalid_n1", m_if[0].awvalid, 1'b1);
        checkOutput("wr0_m0_wvalid_n1",  m_if[0].wvalid,  1'b1);
        checkOutput("wr0_m0_awaddr",     m_if[0].awaddr,  32'h4000_0004);
        checkOutput("wr0_m0_wdata",      m_if[0].wdata,   32'h0000_00A5);
        checkOutput("wr0_m1_awvalid",    m_if[1].awvalid, 1'b0);
        waitB("wr0", lat);
        @(negedge clk);
        checkOutput("wr0_bvalid_after", s_if.bvalid, 1'b0);
        checkOutput("wr0_cap_wstrb",    gen_slv[0].cap_wstrb, 4'hF);
        checkOutput("wr0_m1_idle",      valid_total(1) - base1, 0);
        checkOutput("wr0_m2_idle",      valid_total(2) - base2, 0);

        // Read slave 1 with an arready delay of two cycles
        rdata_val[1] = 32'h1234_5678;
        ar_delay[1]  = 4'd2;
        ar1 = gen_slv[1].ar_cnt;
        rd_q.push_back('{resp: 2'b00, data: 32'h1234_5678});
        applyStimulus("rd1", 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4000_1008);
        checkOutput("rd1_m1_arvalid_n1", m_if[1].arvalid, 1'b1);
        checkOutput("rd1_m1_araddr",     m_if[1].araddr,  32'h4000_1008);
        waitR("rd1", lat);
        @(negedge clk);
        checkOutput("rd1_rvalid_after",    s_if.rvalid, 1'b0);
        checkOutput("rd1_arvalid_cycles",  gen_slv[1].ar_cnt - ar1, 3);
        ar_delay[1] = 4'd0;

        // Unmapped write just above the last window
        base_all = valid_total(0) + valid_total(1) + valid_total(2);
        wr_q.push_back('{resp: 2'b11, data: 32'h0});
        applyStimulus("wrmiss", 1'b1, 32'h4000_3000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
        waitB("wrmiss", lat);
        checkOutput("wrmiss_latency", lat, 0);
        @(negedge clk);
        checkOutput("wrmiss_bvalid_after", s_if.bvalid, 1'b0);

        // Unmapped read just below the base
        rd_q.push_back('{resp: 2'b11, data: 32'h0});
        applyStimulus("rdmiss", 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h3FFF_FFFC);
        waitR("rdmiss", lat);
        checkOutput("rdmiss_latency", lat, 0);
        @(negedge clk);
        checkOutput("miss_no_m_valid", valid_total(0) + valid_total(1) + valid_total(2) - base_all, 0);

        // AW presented three cycles ahead of W
        s_if.awaddr  = 32'h4000_0010;
        s_if.awvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("skew_awready_c%0d", k), s_if.awready, 1'b0);
            @(negedge clk);
        end
        wr_q.push_back('{resp: 2'b00, data: 32'h0});
        applyStimulus("skew", 1'b1, 32'h4000_0010, 32'h0000_5A5A, 4'h3, 1'b0, 32'h0);
        waitB("skew", lat);
        @(negedge clk);
        checkOutput("skew_cap_wdata", gen_slv[0].cap_wdata, 32'h0000_5A5A);

        // Slow awready on slave 0, immediate wready
        aw_delay[0] = 4'd3;
        aw0 = gen_slv[0].aw_cnt;
        w0  = gen_slv[0].w_cnt;
        wr_q.push_back('{resp: 2'b00, data: 32'h0});
        applyStimulus("slowaw", 1'b1, 32'h4000_0020, 32'h0000_0042, 4'hF, 1'b0, 32'h0);
        waitB("slowaw", lat);
        @(negedge clk);
        checkOutput("slowaw_awvalid_cycles", gen_slv[0].aw_cnt - aw0, 4);
        checkOutput("slowaw_wvalid_cycles",  gen_slv[0].w_cnt - w0,   1);
        repeat (3) @(negedge clk);
        checkOutput("slowaw_single_resp", s_if.bvalid, 1'b0);
        aw_delay[0] = 4'd0;

        // Concurrent write to slave 0 and read from slave 2 under backpressure
        rdata_val[2] = 32'hDEAD_BEEF;
        s_if.bready  = 1'b0;
        s_if.rready  = 1'b0;
        wr_q.push_back('{resp: 2'b00, data: 32'h0});
        rd_q.push_back('{resp: 2'b00, data: 32'hDEAD_BEEF});
        applyStimulus("conc", 1'b1, 32'h4000_0030, 32'h0000_CAFE, 4'hF, 1'b1, 32'h4000_2000);
        waitB("conc", lat);
        s_if.awaddr  = 32'h4000_1000;
        s_if.wdata   = 32'h0000_0077;
        s_if.wstrb   = 4'hF;
        s_if.awvalid = 1'b1;
        s_if.wvalid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("hold_bvalid_c%0d", k),  s_if.bvalid,  1'b1);
            checkOutput($sformatf("hold_bresp_c%0d", k),   s_if.bresp,   2'b00);
            checkOutput($sformatf("hold_awready_c%0d", k), s_if.awready, 1'b0);
            checkOutput($sformatf("hold_rdata_c%0d", k),   s_if.rdata,   32'hDEAD_BEEF);
            @(negedge clk);
        end
        s_if.bready = 1'b1;
        @(negedge clk);
        wr_q.push_back('{resp: 2'b00, data: 32'h0});
        applyStimulus("afterhold", 1'b1, 32'h4000_1000, 32'h0000_0077, 4'hF, 1'b0, 32'h0);
        waitB("afterhold", lat);
        @(negedge clk);
        checkOutput("afterhold_cap_awaddr", gen_slv[1].cap_awaddr, 32'h4000_1000);
        waitR("conc", lat);
        s_if.rready = 1'b1;
        @(negedge clk);
        checkOutput("conc_rvalid_after",  s_if.rvalid, 1'b0);
        checkOutput("conc_cap_araddr",    gen_slv[2].cap_araddr, 32'h4000_2000);
        checkOutput("conc_cap_wdata0",    gen_slv[0].cap_wdata,  32'h0000_CAFE);

        // Reset while slave 0 is stalling awready
        aw_delay[0] = 4'd5;
        applyStimulus("rstmid", 1'b1, 32'h4000_0040, 32'h0000_0099, 4'hF, 1'b0, 32'h0);
        checkOutput("rstmid_awvalid_before", m_if[0].awvalid, 1'b1);
        checkOutput("rstmid_wvalid_before",  m_if[0].wvalid,  1'b1);
        #2;
        arstn = 1'b0;
        #1;
        checkOutput("rstmid_awvalid_async", m_if[0].awvalid, 1'b0);
        checkOutput("rstmid_wvalid_async",  m_if[0].wvalid,  1'b0);
        repeat (2) @(negedge clk);
        arstn       = 1'b1;
        aw_delay[0] = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("rstmid_no_resp", s_if.bvalid, 1'b0);
        wr_q.push_back('{resp: 2'b00, data: 32'h0});
        applyStimulus("postrst", 1'b1, 32'h4000_1040, 32'h0000_0055, 4'hF, 1'b0, 32'h0);
        waitB("postrst", lat);
        @(negedge clk);
        checkOutput("postrst_cap_awaddr", gen_slv[1].cap_awaddr, 32'h4000_1040);
        checkOutput("postrst_cap_wdata",  gen_slv[1].cap_wdata,  32'h0000_0055);

        checkOutput("wr_sb_drained", wr_q.size(), 0);
        checkOutput("rd_sb_drained", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
